// File: rtl/cem_pkg.sv
// Shared constants for the counter event monitor: default widths, event bit map, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cem_pkg;

    // Default configuration
    localparam int CEM_CNT_W   = 8;
    localparam int CEM_NUM_CMP = 2;
    localparam int CEM_TS_W    = 24;
    localparam int CEM_EVC_W   = 16;

    // Event bit positions for the default configuration: match bits sit at
    // [NUM_CMP-1:0], wrap events directly above them.
    localparam int EVT_OVF = CEM_NUM_CMP;
    localparam int EVT_UNF = CEM_NUM_CMP + 1;

    // Detection FSM
    localparam logic [0:0] ST_PRIME = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/count_event_monitor_if.sv
// Bus between the host wire/trigger side and the counter event monitor.
// Latency: n/a (wiring only).
// Backpressure: none; all outputs are pulses or levels with no ready.
//   master : drives count, cmp_val, cmp_en, clear, snap_req; observes status
//   slave  : the monitor; observes inputs, drives evt_trig/sticky/snap_*
interface count_event_monitor_if
    import cem_pkg::*;
#(
    parameter int CNT_W   = CEM_CNT_W,
    parameter int NUM_CMP = CEM_NUM_CMP,
    parameter int TS_W    = CEM_TS_W,
    parameter int EVC_W   = CEM_EVC_W
);
    logic [CNT_W-1:0]         count;
    logic [NUM_CMP*CNT_W-1:0] cmp_val;
    logic [NUM_CMP-1:0]       cmp_en;
    logic                     clear;
    logic                     snap_req;

    logic [NUM_CMP+1:0]       evt_trig;
    logic [NUM_CMP+1:0]       sticky;
    logic [NUM_CMP+1:0]       snap_sticky;
    logic [EVC_W-1:0]         snap_evcnt;
    logic [TS_W-1:0]          snap_ts;
    logic                     snap_valid;

    modport master (
        output count, cmp_val, cmp_en, clear, snap_req,
        input  evt_trig, sticky, snap_sticky, snap_evcnt, snap_ts, snap_valid
    );

    modport slave (
        input  count, cmp_val, cmp_en, clear, snap_req,
        output evt_trig, sticky, snap_sticky, snap_evcnt, snap_ts, snap_valid
    );

endinterface

// File: rtl/cem_cmp_chan.sv
// One compare channel: flags entry of the counter onto the programmed value.
// Latency: combinational (registered by the parent).
// Backpressure: none.
//   cur/prev : current and previous sampled counter value
//   cmp_val  : compare value, en : channel enable, hit : entry detected
module cem_cmp_chan #(
    parameter int W = 8
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] prev,
    input  logic [W-1:0] cmp_val,
    input  logic         en,
    output logic         hit
);

    // Requiring cur != prev makes this an entry detector: holding at the
    // value, or moving cmp_val onto a static counter, never fires.
    assign hit = en && (cur == cmp_val) && (cur != prev);

endmodule

// File: rtl/count_event_monitor.sv
// Watches a board counter for compare-match entry and max<->0 wraps; keeps sticky/count/timestamp status with host snapshot.
// Latency: counter change to evt_trig pulse = 2 sys_clk edges; snap_req to snap_valid = 1 edge.
// Backpressure: none; evt_trig and snap_valid are single-cycle pulses the host must take as they come.
//   sys_clk, reset_n : clock and asynchronous active-low reset
//   bus (slave)      : count/cmp_val/cmp_en/clear/snap_req in; evt_trig/sticky/snap_* out
module count_event_monitor
    import cem_pkg::*;
#(
    parameter int CNT_W   = CEM_CNT_W,
    parameter int NUM_CMP = CEM_NUM_CMP,
    parameter int TS_W    = CEM_TS_W,
    parameter int EVC_W   = CEM_EVC_W
) (
    input  logic            sys_clk,
    input  logic            reset_n,
    count_event_monitor_if.slave bus
);

    localparam int EVT_W   = NUM_CMP + 2;
    // Package constants describe the default map; other channel counts shift
    // the wrap bits to sit just above the match bits.
    localparam int IDX_OVF = (NUM_CMP == CEM_NUM_CMP) ? EVT_OVF : NUM_CMP;
    localparam int IDX_UNF = (NUM_CMP == CEM_NUM_CMP) ? EVT_UNF : NUM_CMP + 1;

    logic [0:0]       state_q;
    logic [CNT_W-1:0] cur_q;
    logic [CNT_W-1:0] prev_q;
    logic             clear_q;
    logic [TS_W-1:0]  ts_q;
    logic [TS_W-1:0]  last_ts_q;
    logic [EVC_W-1:0] evcnt_q;
    logic [EVT_W-1:0] evt_q;
    logic [EVT_W-1:0] sticky_q;
    logic [EVT_W-1:0] snap_sticky_q;
    logic [EVC_W-1:0] snap_evcnt_q;
    logic [TS_W-1:0]  snap_ts_q;
    logic             snap_valid_q;

    logic [NUM_CMP-1:0] hit;
    logic [EVT_W-1:0]   evt_nxt;
    logic               evt_any;
    logic               clear_rise;
    logic [EVT_W-1:0]   sticky_nxt;
    logic [EVC_W-1:0]   evcnt_base;
    logic [EVC_W-1:0]   evcnt_nxt;
    logic [TS_W-1:0]    last_ts_nxt;

    for (genvar i = 0; i < NUM_CMP; i++) begin : g_chan
        cem_cmp_chan #(.W(CNT_W)) u_chan (
            .cur     (cur_q),
            .prev    (prev_q),
            .cmp_val (bus.cmp_val[i*CNT_W +: CNT_W]),
            .en      (bus.cmp_en[i]),
            .hit     (hit[i])
        );
    end

    always_comb begin
        evt_nxt = '0;
        if (state_q == ST_RUN) begin
            evt_nxt[NUM_CMP-1:0] = hit;
            evt_nxt[IDX_OVF]     = (prev_q == '1) && (cur_q == '0);
            evt_nxt[IDX_UNF]     = (prev_q == '0) && (cur_q == '1);
        end
    end

    assign evt_any    = |evt_nxt;
    assign clear_rise = bus.clear && !clear_q;

    // Clear is applied before the same-cycle event is folded in, so an event
    // coincident with clear survives as the first post-clear record.
    always_comb begin
        sticky_nxt = (clear_rise ? '0 : sticky_q) | evt_nxt;
        evcnt_base = clear_rise ? '0 : evcnt_q;
        evcnt_nxt  = evcnt_base;
        if (evt_any && (evcnt_base != '1)) begin
            evcnt_nxt = evcnt_base + EVC_W'(1);
        end
        last_ts_nxt = clear_rise ? '0 : last_ts_q;
        if (evt_any) begin
            last_ts_nxt = ts_q;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_PRIME;
            cur_q         <= '0;
            prev_q        <= '0;
            clear_q       <= 1'b0;
            ts_q          <= '0;
            last_ts_q     <= '0;
            evcnt_q       <= '0;
            evt_q         <= '0;
            sticky_q      <= '0;
            snap_sticky_q <= '0;
            snap_evcnt_q  <= '0;
            snap_ts_q     <= '0;
            snap_valid_q  <= 1'b0;
        end else begin
            state_q <= ST_RUN;
            cur_q   <= bus.count;
            // PRIME seeds both history stages with the same sample so the
            // first compare after reset sees no change.
            prev_q  <= (state_q == ST_PRIME) ? bus.count : cur_q;
            clear_q <= bus.clear;
            ts_q    <= ts_q + TS_W'(1);

            evt_q     <= evt_nxt;
            sticky_q  <= sticky_nxt;
            evcnt_q   <= evcnt_nxt;
            last_ts_q <= last_ts_nxt;

            // Snapshot takes next-state values so an event or clear landing
            // on the same edge is included.
            snap_valid_q <= bus.snap_req;
            if (bus.snap_req) begin
                snap_sticky_q <= sticky_nxt;
                snap_evcnt_q  <= evcnt_nxt;
                snap_ts_q     <= last_ts_nxt;
            end
        end
    end

    assign bus.evt_trig    = evt_q;
    assign bus.sticky      = sticky_q;
    assign bus.snap_sticky = snap_sticky_q;
    assign bus.snap_evcnt  = snap_evcnt_q;
    assign bus.snap_ts     = snap_ts_q;
    assign bus.snap_valid  = snap_valid_q;

endmodule

// File: tb/tb_count_event_monitor.sv
// Bench for count_event_monitor: directed stimulus with scoreboard queues checked by a monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_count_event_monitor;
    import cem_pkg::*;

    logic sys_clk;
    logic reset_n;

    count_event_monitor_if #(.CNT_W(8), .NUM_CMP(2), .TS_W(24), .EVC_W(16)) bus ();

    count_event_monitor #(.CNT_W(8), .NUM_CMP(2), .TS_W(24), .EVC_W(16)) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Edges since reset release: equals the DUT timestamp after each edge.
    int edge_cnt;
    always @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    // Scoreboard queues
    logic [3:0]  evt_bits_q[$];
    int          evt_edge_q[$];
    logic [3:0]  snap_st_q[$];
    logic [15:0] snap_ev_q[$];
    logic [23:0] snap_ts_q[$];
    int          snap_edge_q[$];
    string       probe_name_q[$];
    logic [52:0] probe_exp_q[$];
    logic [52:0] probe_mask_q[$];

    int total;
    int bad;
    int last_evt_ts;
    bit done;

    function automatic logic [52:0] mk(logic [3:0] e, logic [3:0] s, logic [3:0] ss,
                                       logic [15:0] ev, logic [23:0] t, logic v);
        return {e, s, ss, ev, t, v};
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Count change driven now is sampled next edge and pulses on the one after.
    task automatic exp_evt(logic [3:0] bits);
        evt_bits_q.push_back(bits);
        evt_edge_q.push_back(edge_cnt + 2);
        last_evt_ts = edge_cnt + 1;
    endtask

    task automatic exp_snap(logic [3:0] st, logic [15:0] ev, logic [23:0] ts);
        snap_st_q.push_back(st);
        snap_ev_q.push_back(ev);
        snap_ts_q.push_back(ts);
        snap_edge_q.push_back(edge_cnt + 1);
    endtask

    task automatic probe(string name, logic [52:0] exp, logic [52:0] mask);
        probe_name_q.push_back(name);
        probe_exp_q.push_back(exp);
        probe_mask_q.push_back(mask);
    endtask

    task automatic do_snap(logic [3:0] st, logic [15:0] ev, logic [23:0] ts);
        bus.snap_req = 1'b1;
        exp_snap(st, ev, ts);
        tick(1);
        bus.snap_req = 1'b0;
        tick(2);
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    always @(negedge sys_clk) begin
        logic [52:0] obs;
        logic [52:0] pe;
        logic [52:0] pm;
        string       pn;
        logic [3:0]  eb;
        int          ee;
        obs = {bus.evt_trig, bus.sticky, bus.snap_sticky, bus.snap_evcnt, bus.snap_ts, bus.snap_valid};
        while (probe_name_q.size() != 0) begin
            pn = probe_name_q.pop_front();
            pe = probe_exp_q.pop_front();
            pm = probe_mask_q.pop_front();
            total++;
            if ((obs & pm) !== (pe & pm)) begin
                bad++;
                $display("FAIL %s: got=%h want=%h", pn, obs & pm, pe & pm);
            end
        end
        if (reset_n && bus.evt_trig != 4'b0) begin
            total++;
            if (evt_bits_q.size() == 0) begin
                bad++;
                $display("FAIL evt_spurious: got=%b at edge %0d want=no pulse", bus.evt_trig, edge_cnt);
            end else begin
                eb = evt_bits_q.pop_front();
                ee = evt_edge_q.pop_front();
                if (bus.evt_trig !== eb || edge_cnt != ee) begin
                    bad++;
                    $display("FAIL evt_trig: got=%b@%0d want=%b@%0d", bus.evt_trig, edge_cnt, eb, ee);
                end
            end
        end
        if (reset_n && bus.snap_valid) begin
            total++;
            if (snap_st_q.size() == 0) begin
                bad++;
                $display("FAIL snap_spurious: got=snap_valid at edge %0d want=none", edge_cnt);
            end else begin
                logic [3:0]  xs;
                logic [15:0] xe;
                logic [23:0] xt;
                int          xg;
                xs = snap_st_q.pop_front();
                xe = snap_ev_q.pop_front();
                xt = snap_ts_q.pop_front();
                xg = snap_edge_q.pop_front();
                if (bus.snap_sticky !== xs || bus.snap_evcnt !== xe || bus.snap_ts !== xt || edge_cnt != xg) begin
                    bad++;
                    $display("FAIL snapshot: got st=%b ev=%h ts=%h @%0d want st=%b ev=%h ts=%h @%0d",
                             bus.snap_sticky, bus.snap_evcnt, bus.snap_ts, edge_cnt, xs, xe, xt, xg);
                end
            end
        end
        if (done) begin
            total++;
            if (evt_bits_q.size() != 0) begin
                bad++;
                $display("FAIL evt_missing: got=%0d unseen pulses want=0", evt_bits_q.size());
            end
            total++;
            if (snap_st_q.size() != 0) begin
                bad++;
                $display("FAIL snap_missing: got=%0d unseen snapshots want=0", snap_st_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=still running want=finished");
        $fatal(1, "watchdog");
    end

    localparam logic [52:0] ALL   = '1;
    localparam logic [3:0]  B_OVF = 4'b0001 << EVT_OVF;
    localparam logic [3:0]  B_UNF = 4'b0001 << EVT_UNF;

    initial begin
        total       = 0;
        bad         = 0;
        done        = 1'b0;
        last_evt_ts = 0;
        reset_n      = 1'b0;
        bus.count    = 8'h05;
        bus.cmp_val  = 16'h0005;
        bus.cmp_en   = 2'b01;
        bus.clear    = 1'b0;
        bus.snap_req = 1'b0;

        // 1: reset state, then PRIME with count already at compare value
        tick(3);
        probe("reset_outputs", mk(0, 0, 0, 0, 0, 0), ALL);
        tick(1);
        reset_n = 1'b1;
        tick(6);
        probe("prime_sticky", mk(0, 0, 0, 0, 0, 0), mk(0, 4'hF, 0, 0, 0, 0));

        // 2: match entry pulses once, holding does not repeat
        bus.count = 8'h04;
        tick(3);
        bus.count = 8'h05;
        exp_evt(4'b0001);
        tick(12);
        do_snap(4'b0001, 16'd1, 24'(last_evt_ts));

        // 3: wraps, non-wrap reset to 0, coincident match+ovf
        bus.count = 8'hFF;
        tick(3);
        bus.count = 8'h00; exp_evt(B_OVF); tick(3);
        bus.count = 8'hFF; exp_evt(B_UNF); tick(3);
        bus.count = 8'h37; tick(3);
        bus.count = 8'h00; tick(3);
        bus.cmp_en = 2'b11; tick(3);
        bus.count = 8'hFF; exp_evt(B_UNF); tick(3);
        bus.count = 8'h00; exp_evt(B_OVF | 4'b0010); tick(3);
        bus.cmp_en = 2'b01;
        probe("sticky_all", mk(0, 4'hF, 0, 0, 0, 0), mk(0, 4'hF, 0, 0, 0, 0));
        do_snap(4'b1111, 16'd5, 24'(last_evt_ts));

        // 4: clear rising on the same edge as a match event
        bus.count = 8'h05;
        exp_evt(4'b0001);
        tick(1);
        bus.clear = 1'b1;
        tick(1);
        do_snap(4'b0001, 16'd1, 24'(last_evt_ts));
        probe("sticky_after_clear", mk(0, 4'b0001, 0, 0, 0, 0), mk(0, 4'hF, 0, 0, 0, 0));
        bus.clear = 1'b0;
        tick(1);
        // clear edge with snap, then back-to-back snap
        bus.clear    = 1'b1;
        bus.snap_req = 1'b1;
        exp_snap(4'b0, 16'd0, 24'd0);
        tick(1);
        exp_snap(4'b0, 16'd0, 24'd0);
        tick(1);
        bus.snap_req = 1'b0;
        bus.clear    = 1'b0;
        tick(2);

        // 5: event counter saturation
        bus.cmp_en = 2'b00;
        bus.count  = 8'hFF;
        tick(3);
        for (int i = 0; i < 65539; i++) begin
            if (i % 2 == 0) begin bus.count = 8'h00; exp_evt(B_OVF); end
            else            begin bus.count = 8'hFF; exp_evt(B_UNF); end
            tick(1);
        end
        tick(3);
        do_snap(B_OVF | B_UNF, 16'hFFFF, 24'(last_evt_ts));
        probe("sticky_wraps", mk(0, B_OVF | B_UNF, 0, 0, 0, 0), mk(0, 4'hF, 0, 0, 0, 0));
        tick(1);

        // 6: asynchronous reset mid-cycle, then PRIME and a clean first event
        bus.cmp_en = 2'b01;
        #2;
        reset_n = 1'b0;
        probe("async_reset", mk(0, 0, 0, 0, 0, 0), ALL);
        tick(1);
        bus.count = 8'h10;
        tick(1);
        reset_n = 1'b1;
        tick(3);
        bus.count = 8'h05;
        exp_evt(4'b0001);
        tick(4);
        probe("sticky_post_reset", mk(0, 4'b0001, 0, 0, 0, 0), mk(0, 4'hF, 0, 0, 0, 0));
        tick(1);
        done = 1'b1;
    end

endmodule
